// File: rtl/cnn_mac_arb.sv
// cnn_mac_arb: two-requester round-robin front end for one shared signed
// 14x9 MAC. A granted requester streams KLEN pixel/weight pairs, the block
// accumulates them and presents the sum with the owner's index.
// Optional build macro CNN_MAC_ARB_RELU_EN clamps negative sums to zero.
module cnn_mac_arb #(
  parameter int KLEN  = 9,
  parameter int ACC_W = 27
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [13:0]      req0_pix,
  input  logic [8:0]       req0_wgt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [13:0]      req1_pix,
  input  logic [8:0]       req1_wgt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_id
);

  localparam int CNT_W = $clog2(KLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, OUT} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              dcnt;       // counts the two DRAIN cycles
  logic              gnt;        // requester owning the current burst
  logic              prio;       // requester that wins the next tie
  logic              any_req, win, sel_valid, busy_rdy, accept, start;
  logic [13:0]       op_pix;
  logic [8:0]        op_wgt;
  logic [22:0]       prod;
  logic [ACC_W-1:0]  acc;
  logic [1:0]        vld_pipe;   // [0] operands valid, [1] product valid

  assign any_req   = req0_valid | req1_valid;
  // single requester wins outright; on a tie the pointer decides
  assign win       = (req0_valid & req1_valid) ? prio : req1_valid;
  assign sel_valid = gnt ? req1_valid : req0_valid;
  assign busy_rdy  = (state == BUSY) && (cnt < CNT_W'(KLEN));
  assign accept    = busy_rdy & sel_valid;
  assign start     = (state == IDLE) & any_req;

  // next-state and handshake outputs
  always_comb begin
    state_nx   = state;
    req0_ready = busy_rdy & ~gnt;
    req1_ready = busy_rdy & gnt;
    res_valid  = (state == OUT);
    case (state)
      IDLE:  if (any_req) state_nx = BUSY;
      BUSY:  if (accept && cnt == CNT_W'(KLEN - 1)) state_nx = DRAIN;
      DRAIN: if (dcnt) state_nx = OUT;
      OUT:   if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nx;
  end

  // drain timer: 0 on entry, flips once, leaves on the second cycle
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) dcnt <= 1'b0;
    else           dcnt <= (state == DRAIN) ? ~dcnt : 1'b0;
  end

  // grant, round-robin pointer and pair counter
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      gnt  <= 1'b0;
      prio <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      gnt  <= win;
      prio <= ~win;
      cnt  <= '0;
    end else if (accept) begin
      cnt  <= cnt + 1'b1;
    end
  end

  // operand mux feeds the single multiplier; product then accumulate
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      op_pix   <= '0;
      op_wgt   <= '0;
      prod     <= '0;
      acc      <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], accept};
      if (accept) begin
        op_pix <= gnt ? req1_pix : req0_pix;
        op_wgt <= gnt ? req1_wgt : req0_wgt;
      end
      // low 23 bits of the sign-extended product equal the signed product
      if (vld_pipe[0])
        prod <= {{9{op_pix[13]}}, op_pix} * {{14{op_wgt[8]}}, op_wgt};
      if (start)
        acc <= '0;
      else if (vld_pipe[1])
        acc <= acc + {{(ACC_W-23){prod[22]}}, prod};
    end
  end

  assign res_id = gnt;

`ifdef CNN_MAC_ARB_RELU_EN
  assign res_data = acc[ACC_W-1] ? '0 : acc;
`else
  assign res_data = acc;
`endif

endmodule

// File: tb/tb_cnn_mac_arb.sv
// Scoreboard bench for cnn_mac_arb: drivers stream bursts, a reference model
// predicts sums and round-robin order, a monitor checks every result.
module tb_cnn_mac_arb;
  localparam int KLEN  = 9;
  localparam int ACC_W = 27;

  typedef logic signed [13:0] pix_a_t [KLEN];
  typedef logic signed [8:0]  wgt_a_t [KLEN];
  typedef struct { bit id; longint data; } exp_t;

  logic             ap_clk = 0, ap_rst_n = 0;
  logic             req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [13:0]      req0_pix = 0, req1_pix = 0;
  logic [8:0]       req0_wgt = 0, req1_wgt = 0;
  logic             res_valid, res_ready, res_id;
  logic [ACC_W-1:0] res_data;

  int     npass = 0, nchk = 0, cyc = 0, last_acc = -100;
  exp_t   exp_q[$];
  bit     nxt = 0;       // model: requester winning the next tie
  bit     rdy_rnd = 0, rdy_force = 1;
  pix_a_t p0, p1;
  wgt_a_t w0, w1;

  cnn_mac_arb #(.KLEN(KLEN), .ACC_W(ACC_W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pix(req0_pix), .req0_wgt(req0_wgt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pix(req1_pix), .req1_wgt(req1_wgt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
  );

  initial forever #5 ap_clk = ~ap_clk;
  initial forever begin @(posedge ap_clk); cyc++; end

  // consumer ready: forced level or random backpressure
  initial begin
    res_ready = 1;
    forever begin
      @(posedge ap_clk); #2;
      res_ready = rdy_rnd ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // reference: plain sum of products, wrapped to ACC_W, optional clamp
  function automatic longint model(input pix_a_t p, input wgt_a_t w);
    longint s = 0;
    logic [ACC_W-1:0] t;
    for (int i = 0; i < KLEN; i++) s += longint'(p[i]) * longint'(w[i]);
    t = s[ACC_W-1:0];
    s = longint'($signed(t));
`ifdef CNN_MAC_ARB_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // expected owner order: a tie goes to nxt, then the loser; the last
  // served requester loses the next tie
  task automatic plan(input bit u0, input bit u1, input longint s0, input longint s1);
    if (u0 && u1) begin
      exp_q.push_back('{nxt, nxt ? s1 : s0});
      exp_q.push_back('{!nxt, nxt ? s0 : s1});
    end else if (u0) begin
      exp_q.push_back('{1'b0, s0}); nxt = 1;
    end else begin
      exp_q.push_back('{1'b1, s1}); nxt = 0;
    end
  endtask

  task automatic fill_const(output pix_a_t p, output wgt_a_t w, input int pv, input int wv);
    for (int i = 0; i < KLEN; i++) begin p[i] = 14'(pv); w[i] = 9'(wv); end
  endtask

  task automatic fill_rand(output pix_a_t p, output wgt_a_t w);
    for (int i = 0; i < KLEN; i++) begin p[i] = 14'($urandom); w[i] = 9'($urandom); end
  endtask

  task automatic drive(input int r, input logic v, input logic [13:0] p, input logic [8:0] w);
    if (r == 0) begin req0_valid = v; req0_pix = p; req0_wgt = w; end
    else        begin req1_valid = v; req1_pix = p; req1_wgt = w; end
  endtask

  // stream n pairs; bub: 0 none, 1 alternate, 2 random (only after first accept)
  task automatic run_burst(input int r, input pix_a_t px, input wgt_a_t wt, input int n,
                           input int bub, input bit chk_other);
    int i = 0, k = 0, wait_c = 0;
    bit v, rdy;
    @(posedge ap_clk); #1;
    while (i < n) begin
      if (i == 0 || bub == 0) v = 1;
      else if (bub == 1)      v = (k % 2 == 0);
      else                    v = ($urandom_range(0, 1) == 1);
      drive(r, v, v ? px[i] : 14'($urandom), v ? wt[i] : 9'($urandom));
      @(negedge ap_clk);
      rdy = (r == 0) ? req0_ready : req1_ready;
      if (chk_other) check("other_ready_low", longint'(r == 0 ? req1_ready : req0_ready), 0);
      if (v && rdy) begin
        i++; wait_c = 0;
        if (i == KLEN) last_acc = cyc;
      end else if (++wait_c > 3000) begin
        check("accept_timeout", longint'(wait_c), 3000);
        break;
      end
      k++;
      @(posedge ap_clk); #1;
    end
    drive(r, 0, 0, 0);
  endtask

  task automatic wait_empty();
    int k = 0;
    while (exp_q.size() != 0 && k < 5000) begin @(negedge ap_clk); k++; end
    if (exp_q.size() != 0) begin
      check("result_timeout", longint'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  // monitor: result compare, stall stability, latency, readys low in OUT
  initial begin
    bit pv = 0, hold = 0, hid = 0;
    logic [ACC_W-1:0] hd = 0;
    exp_t e;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        pv = 0; hold = 0;
      end else begin
        if (res_valid) check("ready_low_in_out", longint'({req0_ready, req1_ready}), 0);
        if (hold) begin
          check("stall_valid", longint'(res_valid), 1);
          check("stall_data", longint'(res_data), longint'(hd));
          check("stall_id", longint'(res_id), longint'(hid));
        end
        if (res_valid && !pv) check("latency", longint'(cyc - last_acc), 3);
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) check("unexpected_result", 0, 1);
          else begin
            e = exp_q.pop_front();
            check("res_id", longint'(res_id), longint'(e.id));
            check("res_data", longint'($signed(res_data)), e.data);
          end
        end
        pv = res_valid; hold = res_valid && !res_ready; hd = res_data; hid = res_id;
      end
    end
  end

  initial begin
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_res_valid", longint'(res_valid), 0);
    check("rst_ready", longint'({req0_ready, req1_ready}), 0);
    check("rst_res_data", longint'(res_data), 0);
    check("rst_res_id", longint'(res_id), 0);
    @(negedge ap_clk); ap_rst_n = 1;

    // tie twice: 0,1 then 0,1 again
    fill_const(p0, w0, 100, 3);
    fill_const(p1, w1, -50, 7);
    repeat (2) begin
      plan(1, 1, model(p0, w0), model(p1, w1));
      fork
        run_burst(0, p0, w0, KLEN, 0, 0);
        run_burst(1, p1, w1, KLEN, 0, 0);
      join
      wait_empty();
    end

    // req0 alone
    plan(1, 0, model(p0, w0), 0);
    run_burst(0, p0, w0, KLEN, 0, 0);
    wait_empty();

    // extremes
    fill_const(p1, w1, -8192, -256);
    plan(0, 1, 0, model(p1, w1));
    run_burst(1, p1, w1, KLEN, 0, 0);
    wait_empty();
    fill_const(p0, w0, -8192, 255);
    plan(1, 0, model(p0, w0), 0);
    run_burst(0, p0, w0, KLEN, 0, 0);
    wait_empty();

    // alternate-cycle bubbles on req1, req0 ready must stay low
    fill_const(p1, w1, 1, 1);
    plan(0, 1, 0, model(p1, w1));
    run_burst(1, p1, w1, KLEN, 1, 1);
    wait_empty();

    // stall in OUT for 5 cycles while req0 waits
    rdy_force = 0;
    fill_rand(p1, w1);
    fill_rand(p0, w0);
    plan(0, 1, 0, model(p1, w1));
    plan(1, 0, model(p0, w0), 0);
    run_burst(1, p1, w1, KLEN, 0, 0);
    fork
      run_burst(0, p0, w0, KLEN, 0, 0);
      begin
        for (int k = 0; k < 50 && !res_valid; k++) @(negedge ap_clk);
        check("stall_seen", longint'(res_valid), 1);
        repeat (5) @(negedge ap_clk);
        @(posedge ap_clk); #1;
        rdy_force = 1;
        @(negedge ap_clk);
        @(negedge ap_clk);
        check("idle_after_ack", longint'(res_valid), 0);
        check("idle_no_ready", longint'(req0_ready), 0);
      end
    join
    wait_empty();

    // reset after 4 accepted pairs
    fill_const(p0, w0, 50, 7);
    run_burst(0, p0, w0, 4, 0, 0);
    repeat (2) @(posedge ap_clk);
    #3 ap_rst_n = 0;
    #1;
    check("mid_rst_res_valid", longint'(res_valid), 0);
    check("mid_rst_ready", longint'({req0_ready, req1_ready}), 0);
    check("mid_rst_res_data", longint'(res_data), 0);
    check("mid_rst_res_id", longint'(res_id), 0);
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk); ap_rst_n = 1;
    nxt = 0;
    fill_const(p0, w0, 2, 2);
    plan(1, 0, model(p0, w0), 0);
    run_burst(0, p0, w0, KLEN, 0, 0);
    wait_empty();

    // random bursts, random requester sets, bubbles and backpressure
    rdy_rnd = 1;
    for (int it = 0; it < 30; it++) begin
      int sel, bm0, bm1;
      bit u0, u1;
      sel = $urandom_range(1, 3);
      u0  = sel[0];
      u1  = sel[1];
      bm0 = ($urandom_range(0, 1) == 1) ? 2 : 0;
      bm1 = ($urandom_range(0, 1) == 1) ? 2 : 0;
      fill_rand(p0, w0);
      fill_rand(p1, w1);
      plan(u0, u1, model(p0, w0), model(p1, w1));
      fork
        if (u0) run_burst(0, p0, w0, KLEN, bm0, 0);
        if (u1) run_burst(1, p1, w1, KLEN, bm1, 0);
      join
      wait_empty();
    end
    rdy_rnd = 0;
    repeat (3) @(posedge ap_clk);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/cnn_mac_arb.md
CNN_MAC_ARB -- requirements
Module: cnn_mac_arb

Interface
REQ-001 SHALL have parameter KLEN, default 9: number of pixel/weight pairs per kernel burst (3x3 conv window).
REQ-002 SHALL have parameter ACC_W, default 27: accumulator and result width.
REQ-003 SHALL have port ap_clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port ap_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid, req1_valid, input, 1 each: requester has an operand pair.
REQ-006 SHALL have ports req0_ready, req1_ready, output, 1 each: pair accepted when valid and ready are both high.
REQ-007 SHALL have ports req0_pix, req1_pix, input, 14 each: signed pixel operand.
REQ-008 SHALL have ports req0_wgt, req1_wgt, input, 9 each: signed weight operand.
REQ-009 SHALL have port res_valid, output, 1: result available.
REQ-010 SHALL have port res_ready, input, 1: consumer accepts result.
REQ-011 SHALL have port res_data, output, ACC_W: signed sum of KLEN products.
REQ-012 SHALL have port res_id, output, 1: index of the requester that owns res_data.

Function
REQ-013 SHALL contain exactly one signed 14x9 -> 23-bit multiplier, shared by both requesters.
REQ-014 SHALL use FSM states IDLE, BUSY, DRAIN, OUT.
REQ-015 IDLE: with any reqN_valid high, SHALL grant one requester, clear the accumulator and the pair counter, and go to BUSY next cycle. No pair is accepted in IDLE.
REQ-016 Arbitration SHALL be round-robin. With both valid, the requester not granted last wins. After reset, req0 wins the first tie.
REQ-017 BUSY: only the granted reqN_ready SHALL be high, and only while the counter is below KLEN. The other ready stays low.
REQ-018 Granted-requester valid gaps (bubbles) SHALL be tolerated. The counter advances only on accepted pairs.
REQ-019 Pipeline timing for a pair accepted at cycle T:
- operands registered at the end of T;
- 23-bit product registered at T+1;
- product sign-extended to ACC_W and added into the accumulator at T+2.
REQ-020 On the KLEN-th accept, the FSM SHALL go to DRAIN for 2 cycles, then to OUT. res_valid SHALL rise exactly 3 cycles after the final accept cycle.
REQ-021 OUT: res_valid high; res_data and res_id stable until res_valid and res_ready are both high. The FSM then goes to IDLE.
REQ-022 res_ready held high SHALL give a one-cycle res_valid pulse. res_ready low SHALL stall the FSM in OUT indefinitely, with both readys low.
REQ-023 Accumulation SHALL use two's-complement wrap at ACC_W bits. ACC_W >= 23+ceil(log2(KLEN)) guarantees no overflow; the default values satisfy this.
REQ-024 A new grant SHALL NOT occur until the previous result is consumed. A request that arrives while the block is busy waits, and its valid is held by the requester.

Reset
REQ-025 ap_rst_n low SHALL asynchronously force:
- FSM to IDLE;
- counter, accumulator and pipeline registers to 0;
- res_valid, req0_ready, req1_ready to 0;
- res_data to 0 and res_id to 0;
- round-robin pointer so that req0 wins next.
REQ-026 Reset mid-burst SHALL discard the partial sum. No result is emitted for that burst, and requesters restart from pair 0.
REQ-027 Deassertion of ap_rst_n SHALL be sampled synchronously. The first grant can occur on the first edge after release.

Configuration
REQ-028 With macro CNN_MAC_ARB_RELU_EN defined, res_data SHALL equal max(sum, 0): negative sums output 0.
REQ-029 Without CNN_MAC_ARB_RELU_EN, res_data SHALL be the raw signed sum. Timing and latency SHALL be identical in both builds.

Verification
REQ-030 req0 alone, 9 pairs of pix=100, wgt=3 with no bubbles -> res_data=2700, res_id=0, res_valid 3 cycles after the 9th accept.
REQ-031 Both requesters valid in IDLE after reset -> req0 granted first, req1 granted after req0's result is consumed. Repeating the tie -> grants alternate 0,1,0,1.
REQ-032 Extremes: 9 pairs of pix=-8192, wgt=-256 -> 18874368. 9 pairs of pix=-8192, wgt=255 -> -18800640 without the macro, 0 with CNN_MAC_ARB_RELU_EN.
REQ-033 Bubbles: req1_valid low on alternate cycles during a 9-pair burst of pix=1, wgt=1 -> res_data=9, and req0_ready stays 0 throughout.
REQ-034 res_ready held low for 5 cycles in OUT -> res_valid and res_data stable, both readys 0, no new grant. Then res_ready=1 -> IDLE next cycle.
REQ-035 ap_rst_n pulsed low after 4 accepted pairs -> all outputs 0 immediately. A fresh 9-pair burst of pix=2, wgt=2 then gives res_data=36.
